// File: rtl/timer_bus_regs.sv
// timer_bus_regs: APB-style register front end for the 8-bit timer counter.
// Optional macro TIMER_BUS_REGS_PSLVERR_EN enables error responses for unmapped addresses and TCNT writes.
module timer_bus_regs #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] start_counter,
  output logic       up_down,
  output logic       load,
  output logic       enable,
  output logic [1:0] clk_sel,
  output logic       clr_overflow,
  output logic       clr_underflow,
  input  logic [7:0] tcnt,
  input  logic       overflow,
  input  logic       underflow,
  output logic       irq
);

  localparam int unsigned CNT_W = 2;
  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} state_t;

  state_t           state_q, state_d, cur_c;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             ovie_q, udie_q;
  logic             commit_c, err_c, wr_c;
  logic [7:0]       rdata_c;
  logic             unused_c;

  assign unused_c = pwdata[6];

  // The setup phase is recognised from the bus itself, so the transfer spans 2 + WAIT_CYCLES cycles.
  always_comb begin
    cur_c = state_q;
    if ((state_q == IDLE || state_q == ACCESS) && psel && !penable)
      cur_c = SETUP;
  end

  always_comb begin
    state_d = IDLE;
    wait_d  = '0;
    case (cur_c)
      SETUP: state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT: begin
        if (psel) begin
          if (wait_q == WAIT_LAST) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            wait_d  = wait_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign commit_c = (state_q == ACCESS) && psel && penable;

`ifdef TIMER_BUS_REGS_PSLVERR_EN
  assign err_c = (paddr > ADDR_TCNT) || (pwrite && paddr == ADDR_TCNT);
`else
  assign err_c = 1'b0;
`endif

  assign wr_c = commit_c && pwrite && !err_c;

  always_comb begin
    rdata_c = '0;
    case (paddr)
      ADDR_TDR:  rdata_c = start_counter;
      ADDR_TCR:  rdata_c = {2'b00, up_down, enable, ovie_q, udie_q, clk_sel};
      ADDR_TSR:  rdata_c = {6'b000000, underflow, overflow};
      ADDR_TCNT: rdata_c = tcnt;
      default:   rdata_c = '0;
    endcase
  end

  // Response is captured on entry to ACCESS so it is stable for the whole ready cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= (state_d == ACCESS);
      pslverr <= (state_d == ACCESS) && err_c;
      prdata  <= (state_d == ACCESS && !pwrite) ? rdata_c : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_counter <= '0;
      up_down       <= 1'b0;
      enable        <= 1'b0;
      ovie_q        <= 1'b0;
      udie_q        <= 1'b0;
      clk_sel       <= '0;
      load          <= 1'b0;
      clr_overflow  <= 1'b0;
      clr_underflow <= 1'b0;
      irq           <= 1'b0;
    end else begin
      load          <= 1'b0;
      clr_overflow  <= 1'b0;
      clr_underflow <= 1'b0;
      irq           <= (overflow & ovie_q) | (underflow & udie_q);
      if (wr_c) begin
        case (paddr)
          ADDR_TDR: start_counter <= pwdata;
          ADDR_TCR: begin
            load    <= pwdata[7];
            up_down <= pwdata[5];
            enable  <= pwdata[4];
            ovie_q  <= pwdata[3];
            udie_q  <= pwdata[2];
            clk_sel <= pwdata[1:0];
          end
          ADDR_TSR: begin
            clr_overflow  <= pwdata[0];
            clr_underflow <= pwdata[1];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
